// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute controller for the 4-bit Von Neumann CPU
module cpu_sequencer (
  input  logic       clk,
  input  logic       REST,
  input  logic [3:0] OPCODE,
  input  logic       ACC_ZERO,
  input  logic       MEM_READY,
  output logic       IR_LOAD,
  output logic       MAR_SEL,
  output logic       MAR_LOAD,
  output logic       PC_INC,
  output logic       PC_LOAD,
  output logic       MEM_READ,
  output logic       MEM_WRITE,
  output logic       ACC_LOAD,
  output logic [1:0] ALU_OP,
  output logic       OUT_LOAD,
  output logic       HALTED,
  output logic       ILLEGAL,
  output logic [2:0] STATE
);
  typedef enum logic [2:0] {FA = 3'd0, FM = 3'd1, DEC = 3'd2, OA = 3'd3, OM = 3'd4, EX = 3'd5, HALT = 3'd6} state_e;
  localparam logic [3:0] OP_NOP = 4'b0000, OP_LDA = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0011,
                         OP_STA = 4'b0100, OP_JMP = 4'b0101, OP_JZ = 4'b0110, OP_OUT = 4'b1110, OP_HLT = 4'b1111;
  state_e state_q, state_d;
  logic is_acc, has_operand, legal;
  assign is_acc      = OPCODE == OP_LDA || OPCODE == OP_ADD || OPCODE == OP_SUB;
  assign has_operand = OPCODE >= OP_LDA && OPCODE <= OP_JZ;
  assign legal       = OPCODE == OP_NOP || has_operand || OPCODE == OP_OUT || OPCODE == OP_HLT;
  assign STATE       = REST ? 3'd0 : state_q;
  // Outputs are Mealy and forced low by REST in the same cycle, so a pending request drops at once
  always_comb begin
    state_d   = FA;
    IR_LOAD   = 1'b0;
    MAR_SEL   = 1'b0;
    MAR_LOAD  = 1'b0;
    PC_INC    = 1'b0;
    PC_LOAD   = 1'b0;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    ACC_LOAD  = 1'b0;
    ALU_OP    = 2'b00;
    OUT_LOAD  = 1'b0;
    HALTED    = 1'b0;
    ILLEGAL   = 1'b0;
    if (!REST) begin
      case (state_q)
        FA: begin
          MAR_LOAD = 1'b1;
          state_d  = FM;
        end
        FM: begin
          MEM_READ = 1'b1;
          IR_LOAD  = MEM_READY;
          PC_INC   = MEM_READY;
          state_d  = MEM_READY ? DEC : FM;
        end
        DEC: begin
          OUT_LOAD = OPCODE == OP_OUT;
          ILLEGAL  = !legal;
          state_d  = OPCODE == OP_HLT ? HALT : has_operand ? OA : FA;
        end
        OA: begin
          MAR_LOAD = 1'b1;
          state_d  = OM;
        end
        OM: begin
          MEM_READ = 1'b1;
          MAR_SEL  = MEM_READY;
          MAR_LOAD = MEM_READY;
          PC_INC   = MEM_READY;
          state_d  = MEM_READY ? EX : OM;
        end
        EX: begin
          MEM_READ  = is_acc;
          MEM_WRITE = OPCODE == OP_STA;
          ACC_LOAD  = is_acc && MEM_READY;
          ALU_OP    = !ACC_LOAD ? 2'b00 : OPCODE == OP_ADD ? 2'b01 : OPCODE == OP_SUB ? 2'b10 : 2'b00;
          PC_LOAD   = OPCODE == OP_JMP || (OPCODE == OP_JZ && ACC_ZERO);
          state_d   = (is_acc || OPCODE == OP_STA) && !MEM_READY ? EX : FA;
        end
        HALT: begin
          HALTED  = 1'b1;
          state_d = HALT;
        end
        default: state_d = FA;
      endcase
    end
  end
  always_ff @(posedge clk) state_q <= REST ? FA : state_d;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed per-cycle checks of state and strobes for cpu_sequencer
module tb_cpu_sequencer;
  logic clk = 1'b0, REST, ACC_ZERO, MEM_READY;
  logic [3:0] OPCODE;
  logic IR_LOAD, MAR_SEL, MAR_LOAD, PC_INC, PC_LOAD, MEM_READ, MEM_WRITE, ACC_LOAD, OUT_LOAD, HALTED, ILLEGAL;
  logic [1:0] ALU_OP;
  logic [2:0] STATE;
  logic [12:0] obs;
  int compared = 0, mismatched = 0;
  localparam logic [12:0] S_IR = 13'h1000, S_MSEL = 13'h0800, S_MLD = 13'h0400, S_PCI = 13'h0200,
                          S_PCL = 13'h0100, S_MRD = 13'h0080, S_MWR = 13'h0040, S_ACL = 13'h0020,
                          S_SUB = 13'h0010, S_ADD = 13'h0008, S_OUT = 13'h0004, S_HLT = 13'h0002, S_ILL = 13'h0001;
  localparam logic [12:0] FETCH_DONE = S_MRD | S_IR | S_PCI, OPND_DONE = S_MRD | S_MSEL | S_MLD | S_PCI;

  cpu_sequencer dut (
    .clk(clk), .REST(REST), .OPCODE(OPCODE), .ACC_ZERO(ACC_ZERO), .MEM_READY(MEM_READY),
    .IR_LOAD(IR_LOAD), .MAR_SEL(MAR_SEL), .MAR_LOAD(MAR_LOAD), .PC_INC(PC_INC), .PC_LOAD(PC_LOAD),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .ACC_LOAD(ACC_LOAD), .ALU_OP(ALU_OP),
    .OUT_LOAD(OUT_LOAD), .HALTED(HALTED), .ILLEGAL(ILLEGAL), .STATE(STATE)
  );

  assign obs = {IR_LOAD, MAR_SEL, MAR_LOAD, PC_INC, PC_LOAD, MEM_READ, MEM_WRITE, ACC_LOAD, ALU_OP, OUT_LOAD, HALTED, ILLEGAL};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] st, input logic [12:0] ob);
    @(negedge clk);
    compared++;
    assert (STATE === st) else begin
      mismatched++;
      $error("FAIL %s STATE got %0d expected %0d", tag, STATE, st);
    end
    compared++;
    assert (obs === ob) else begin
      mismatched++;
      $error("FAIL %s strobes got %h expected %h", tag, obs, ob);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    REST = 1'b1; OPCODE = 4'b0000; ACC_ZERO = 1'b0; MEM_READY = 1'b0;
    chk("rst0", 3'd0, 13'h0);
    chk("rst1", 3'd0, 13'h0);
    REST = 1'b0; MEM_READY = 1'b1;
    chk("nop_fa", 3'd0, S_MLD);
    chk("nop_fm", 3'd1, FETCH_DONE);
    chk("nop_dec", 3'd2, 13'h0);
    OPCODE = 4'b1110;
    chk("out_fa", 3'd0, S_MLD);
    chk("out_fm", 3'd1, FETCH_DONE);
    chk("out_dec", 3'd2, S_OUT);
    OPCODE = 4'b0010;
    chk("add_fa", 3'd0, S_MLD);
    MEM_READY = 1'b0;
    chk("add_fm_w1", 3'd1, S_MRD);
    chk("add_fm_w2", 3'd1, S_MRD);
    MEM_READY = 1'b1;
    chk("add_fm_rdy", 3'd1, FETCH_DONE);
    MEM_READY = 1'b0;
    chk("add_dec", 3'd2, 13'h0);
    chk("add_oa", 3'd3, S_MLD);
    chk("add_om_w1", 3'd4, S_MRD);
    chk("add_om_w2", 3'd4, S_MRD);
    MEM_READY = 1'b1;
    chk("add_om_rdy", 3'd4, OPND_DONE);
    MEM_READY = 1'b0;
    chk("add_ex_w1", 3'd5, S_MRD);
    chk("add_ex_w2", 3'd5, S_MRD);
    MEM_READY = 1'b1;
    chk("add_ex_rdy", 3'd5, S_MRD | S_ACL | S_ADD);
    OPCODE = 4'b0011;
    chk("sub_fa", 3'd0, S_MLD);
    chk("sub_fm", 3'd1, FETCH_DONE);
    chk("sub_dec", 3'd2, 13'h0);
    chk("sub_oa", 3'd3, S_MLD);
    chk("sub_om", 3'd4, OPND_DONE);
    chk("sub_ex", 3'd5, S_MRD | S_ACL | S_SUB);
    OPCODE = 4'b0001;
    chk("lda_fa", 3'd0, S_MLD);
    chk("lda_fm", 3'd1, FETCH_DONE);
    chk("lda_dec", 3'd2, 13'h0);
    chk("lda_oa", 3'd3, S_MLD);
    chk("lda_om", 3'd4, OPND_DONE);
    chk("lda_ex", 3'd5, S_MRD | S_ACL);
    OPCODE = 4'b0110; ACC_ZERO = 1'b1;
    chk("jz1_fa", 3'd0, S_MLD);
    chk("jz1_fm", 3'd1, FETCH_DONE);
    chk("jz1_dec", 3'd2, 13'h0);
    chk("jz1_oa", 3'd3, S_MLD);
    chk("jz1_om", 3'd4, OPND_DONE);
    chk("jz1_ex", 3'd5, S_PCL);
    ACC_ZERO = 1'b0;
    chk("jz0_fa", 3'd0, S_MLD);
    chk("jz0_fm", 3'd1, FETCH_DONE);
    chk("jz0_dec", 3'd2, 13'h0);
    chk("jz0_oa", 3'd3, S_MLD);
    chk("jz0_om", 3'd4, OPND_DONE);
    MEM_READY = 1'b0;
    chk("jz0_ex", 3'd5, 13'h0);
    OPCODE = 4'b0101; MEM_READY = 1'b1;
    chk("jmp_fa", 3'd0, S_MLD);
    chk("jmp_fm", 3'd1, FETCH_DONE);
    chk("jmp_dec", 3'd2, 13'h0);
    chk("jmp_oa", 3'd3, S_MLD);
    chk("jmp_om", 3'd4, OPND_DONE);
    MEM_READY = 1'b0;
    chk("jmp_ex", 3'd5, S_PCL);
    OPCODE = 4'b1010; MEM_READY = 1'b1;
    chk("ill_fa", 3'd0, S_MLD);
    chk("ill_fm", 3'd1, FETCH_DONE);
    chk("ill_dec", 3'd2, S_ILL);
    OPCODE = 4'b1111;
    chk("hlt_fa", 3'd0, S_MLD);
    chk("hlt_fm", 3'd1, FETCH_DONE);
    chk("hlt_dec", 3'd2, 13'h0);
    for (int i = 0; i < 20; i++) begin
      MEM_READY = i[0];
      chk("halt_hold", 3'd6, S_HLT);
    end
    REST = 1'b1;
    chk("halt_rst", 3'd0, 13'h0);
    REST = 1'b0; OPCODE = 4'b0100; MEM_READY = 1'b1;
    chk("sta_fa", 3'd0, S_MLD);
    chk("sta_fm", 3'd1, FETCH_DONE);
    chk("sta_dec", 3'd2, 13'h0);
    chk("sta_oa", 3'd3, S_MLD);
    chk("sta_om", 3'd4, OPND_DONE);
    MEM_READY = 1'b0;
    chk("sta_ex_w1", 3'd5, S_MWR);
    REST = 1'b1;
    chk("sta_rst", 3'd0, 13'h0);
    REST = 1'b0;
    chk("post_rst_fa", 3'd0, S_MLD);
    chk("post_rst_fm", 3'd1, S_MRD);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
